// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request,
// and holds the IF/ID register plus a one-entry skid buffer for freezes.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Freeze,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_addr,
   output logic        Imem_req,
   output logic [31:0] Imem_addr,
   input  logic        Imem_ready,
   input  logic [31:0] Imem_rdata,
   output logic [31:0] If_id_pc,
   output logic [31:0] If_id_instruction,
   output logic        If_id_valid
);

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]  state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] skid_pc;
   logic [31:0] skid_instruction;

   assign pc_plus4  = pc + 32'd4;
   assign Imem_addr = pc;
   // Only the reset gating reaches the outputs combinationally.
   assign Imem_req  = rst_n & (state == FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= FETCH;
         pc                <= RESET_PC;
         skid_pc           <= '0;
         skid_instruction  <= '0;
         If_id_pc          <= '0;
         If_id_instruction <= '0;
         If_id_valid       <= 1'b0;
      end else if (Branch_taken) begin
         pc               <= Branch_addr & ~32'd3;
         If_id_valid      <= 1'b0;
         skid_pc          <= '0;
         skid_instruction <= '0;
         state            <= FETCH;
      end else if (state == HOLD) begin
         if (!Freeze) begin
            If_id_pc          <= skid_pc;
            If_id_instruction <= skid_instruction;
            If_id_valid       <= 1'b1;
            state             <= FETCH;
         end
      end else if (Imem_ready) begin
         pc <= pc_plus4;
         if (Freeze) begin
            // Park the accepted word so the freeze costs no refetch.
            skid_pc          <= pc_plus4;
            skid_instruction <= Imem_rdata;
            state            <= HOLD;
         end else begin
            If_id_pc          <= pc_plus4;
            If_id_instruction <= Imem_rdata;
            If_id_valid       <= 1'b1;
         end
      end else if (!Freeze) begin
         If_id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared against a queue-based fetch model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Freeze;
   logic        Branch_taken;
   logic [31:0] Branch_addr;
   logic        Imem_req;
   logic [31:0] Imem_addr;
   logic        Imem_ready;
   logic [31:0] Imem_rdata;
   logic [31:0] If_id_pc;
   logic [31:0] If_id_instruction;
   logic        If_id_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   // Reference model: PC, visible IF/ID, and a queue of parked instructions.
   logic [31:0] m_pc;
   entry_t      m_ifid;
   logic        m_valid;
   entry_t      parked[$];

   if_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .Freeze            (Freeze),
      .Branch_taken      (Branch_taken),
      .Branch_addr       (Branch_addr),
      .Imem_req          (Imem_req),
      .Imem_addr         (Imem_addr),
      .Imem_ready        (Imem_ready),
      .Imem_rdata        (Imem_rdata),
      .If_id_pc          (If_id_pc),
      .If_id_instruction (If_id_instruction),
      .If_id_valid       (If_id_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0000_0100;
      m_ifid  = '{32'h0, 32'h0};
      m_valid = 1'b0;
      parked.delete();
   endtask

   task automatic model_edge(input logic frz, input logic rdy, input logic br,
                             input logic [31:0] baddr, input logic [31:0] rdata);
      entry_t e;
      if (br) begin
         m_pc    = {baddr[31:2], 2'b00};
         m_valid = 1'b0;
         parked.delete();
      end else if (parked.size() != 0) begin
         if (!frz) begin
            m_ifid  = parked.pop_front();
            m_valid = 1'b1;
         end
      end else if (rdy) begin
         e.pc    = m_pc + 32'd4;
         e.instr = rdata;
         m_pc    = m_pc + 32'd4;
         if (frz) parked.push_back(e);
         else begin
            m_ifid  = e;
            m_valid = 1'b1;
         end
      end else if (!frz) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".req"},   {31'b0, Imem_req},    {31'b0, rst_n === 1'b1 && parked.size() == 0});
      check({tag, ".addr"},  Imem_addr,            m_pc);
      check({tag, ".valid"}, {31'b0, If_id_valid}, {31'b0, m_valid});
      check({tag, ".pc"},    If_id_pc,             m_ifid.pc);
      check({tag, ".instr"}, If_id_instruction,    m_ifid.instr);
   endtask

   // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
   task automatic step(input string tag, input logic frz, input logic rdy,
                       input logic br, input logic [31:0] baddr, input logic [31:0] rdata);
      Freeze       = frz;
      Imem_ready   = rdy;
      Branch_taken = br;
      Branch_addr  = baddr;
      Imem_rdata   = rdata;
      @(posedge clk);
      model_edge(frz, rdy, br, baddr, rdata);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n        = 1'b0;
      Freeze       = 1'b0;
      Branch_taken = 1'b0;
      Branch_addr  = '0;
      Imem_ready   = 1'b1;
      Imem_rdata   = '0;
      model_reset();

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_all("reset");
      end
      rst_n = 1'b1;
      #1;
      check_all("release");
      step("boot0", 1'b0, 1'b1, 1'b0, 32'h0, $urandom);
      check("boot0.ifpc", If_id_pc, 32'h104);
      step("boot1", 1'b0, 1'b1, 1'b0, 32'h0, $urandom);
      check("boot1.ifpc", If_id_pc, 32'h108);
      check("boot1.addr_abs", Imem_addr, 32'h108);

      // Wait states at 0x20
      step("br20", 1'b0, 1'b1, 1'b1, 32'h20, $urandom);
      step("wait0", 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
      step("wait1", 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
      check("wait1.addr_abs", Imem_addr, 32'h20);
      step("wait_done", 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
      check("wait_done.ifpc", If_id_pc, 32'h24);

      // Freeze concurrent with ready parks the word in the skid buffer
      step("br40", 1'b0, 1'b1, 1'b1, 32'h40, $urandom);
      step("frz0", 1'b1, 1'b1, 1'b0, 32'h0, 32'hAAAA_0001);
      check("frz0.req_abs", {31'b0, Imem_req}, 32'h0);
      step("frz1", 1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      step("frz2", 1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      step("unfrz", 1'b0, 1'b1, 1'b0, 32'h0, $urandom);
      check("unfrz.instr_abs", If_id_instruction, 32'hAAAA_0001);
      check("unfrz.ifpc_abs", If_id_pc, 32'h44);
      step("resume", 1'b0, 1'b1, 1'b0, 32'h0, $urandom);
      check("resume.ifpc_abs", If_id_pc, 32'h48);

      // Branch while parked with Freeze high
      step("hold_in", 1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_0002);
      step("br_hold", 1'b1, 1'b0, 1'b1, 32'h203, $urandom);
      check("br_hold.addr_abs", Imem_addr, 32'h200);
      step("br_hold2", 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
      check("br_hold2.valid_abs", {31'b0, If_id_valid}, 32'h0);

      // Branch concurrent with ready drops the returned word
      step("br_rdy", 1'b0, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF);
      step("after_br", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D);
      check("after_br.instr_abs", If_id_instruction, 32'h0BAD_F00D);

      // Wrap-around
      step("br_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, $urandom);
      step("wrap", 1'b0, 1'b1, 1'b0, 32'h0, $urandom);
      check("wrap.ifpc_abs", If_id_pc, 32'h0);
      check("wrap.addr_abs", Imem_addr, 32'h0);

      // Asynchronous reset while parked
      step("hold_rst", 1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check_all("rst_release");

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step("rand",
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0,
              $urandom,
              $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline. It owns the PC register, drives the instruction-memory request handshake, and holds the IF/ID pipeline register consumed by the decode stage. It is the direct upstream neighbour of the hazard unit. The hazard unit's `Hazard_detected_signal` drives `Freeze` here and stalls fetch. A taken branch from EXE redirects the PC and flushes IF/ID.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Freeze` input 1: hazard stall from hazard unit; hold IF/ID and PC.
- `Branch_taken` input 1: taken branch/jump resolved in EXE.
- `Branch_addr` input 32: target PC; bits [1:0] ignored (treated as 0).
- `Imem_req` output 1: fetch request valid.
- `Imem_addr` output 32: fetch address (= PC).
- `Imem_ready` input 1: memory returns `Imem_rdata` for current `Imem_addr` this cycle; sampled only when `Imem_req`=1.
- `Imem_rdata` input 32: instruction word.
- `If_id_pc` output 32: fetched PC + 4.
- `If_id_instruction` output 32: fetched instruction.
- `If_id_valid` output 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- The FSM has two states: FETCH and HOLD.
- **FETCH:**
  - `Imem_req`=1 and `Imem_addr`=PC.
  - The memory is stateless per cycle. Address changes before `Imem_ready` abandon the old request; no outstanding-request tracking.
- **HOLD:**
  - One instruction is parked in the 64-bit skid buffer (instruction, PC+4).
  - `Imem_req`=0.
- Per-cycle priority, highest first:
  1. `Branch_taken`=1 (any state):
     - PC ← {Branch_addr[31:2],2'b00}.
     - `If_id_valid` ← 0.
     - Skid buffer discarded.
     - State ← FETCH.
     - `Imem_ready`/`Imem_rdata` this cycle are ignored.
     - `Freeze` is ignored this cycle.
  2. HOLD, `Freeze`=1: everything holds.
  3. HOLD, `Freeze`=0:
     - IF/ID ← skid buffer, `If_id_valid` ← 1.
     - State ← FETCH.
     - PC unchanged (already advanced).
  4. FETCH, `Imem_ready`=1, `Freeze`=0:
     - IF/ID ← {PC+4, `Imem_rdata`}, valid ← 1.
     - PC ← PC+4.
  5. FETCH, `Imem_ready`=1, `Freeze`=1:
     - Skid buffer ← {PC+4, `Imem_rdata`}.
     - PC ← PC+4.
     - IF/ID holds.
     - State ← HOLD.
  6. FETCH, `Imem_ready`=0, `Freeze`=0: `If_id_valid` ← 0 (bubble); IF/ID data fields hold.
  7. FETCH, `Imem_ready`=0, `Freeze`=1: IF/ID and PC hold.
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- IF/ID data fields are updated only on the loads above. When valid is cleared, the data is stale and must not be consumed.

## Timing
- **Reset (asynchronous, immediate on `rst_n` low):**
  - PC = `RESET_PC`, state = FETCH.
  - `If_id_pc` = 0, `If_id_instruction` = 0, `If_id_valid` = 0.
  - Skid buffer = 0.
  - `Imem_req` is gated to 0 while `rst_n`=0. `Imem_addr` = `RESET_PC`.
- **First request:** `Imem_req` rises combinationally once `rst_n`=1. First possible capture is the first rising edge after reset release with `Imem_ready`=1.
- **Latency:** instruction accepted at edge N (ready=1) is visible on IF/ID after edge N. Zero-wait memory sustains one instruction per cycle.
- **Freeze / HOLD timing:**
  - A freeze concurrent with ready costs no refetch. The parked instruction enters IF/ID on the first edge with `Freeze`=0.
  - In HOLD no further fetch occurs, so at most one instruction is buffered.
- **Branch timing:**
  - Redirect takes effect on the same edge as `Branch_taken`.
  - `Imem_addr` = target from the next cycle.
  - `If_id_valid`=0 for at least one cycle after a branch.
- **Reset mid-operation:** all state returns to reset values asynchronously, including a parked HOLD instruction and any abandoned request.
- `Imem_req`, `Imem_addr`, and all If_id outputs are glitch-free functions of registers; no input-to-output combinational path except the `rst_n` gating of `Imem_req`.

## Test plan
- **Reset:**
  - Stimulus: `RESET_PC`=32'h100, hold `rst_n`=0 for 3 cycles, then release with `Imem_ready`=1.
  - Required response: during reset `Imem_req`=0 and `If_id_valid`=0. After release, `Imem_addr` = 0x100, 0x104, 0x108 on successive cycles and `If_id_pc` = 0x104, 0x108 with valid=1.
- **Wait states:**
  - Stimulus: `Imem_ready`=0 for 2 cycles at PC=0x20, then 1.
  - Required response: `Imem_addr` stays 0x20 and `If_id_valid`=0 for 2 cycles. Then IF/ID = {0x24, rdata}, valid=1.
- **Freeze with ready (skid buffer):**
  - Stimulus: PC=0x40, rdata=0xAAAA_0001, `Freeze`=1 for 3 cycles, `Imem_ready`=1.
  - Required response: state goes to HOLD, `Imem_req`=0, IF/ID unchanged. One cycle after `Freeze` drops, IF/ID = {0x44, 0xAAAA_0001}, valid=1. Then fetch resumes at 0x44 with no duplicate and no skipped instruction.
- **Branch during HOLD with `Freeze`=1:**
  - Stimulus: `Branch_taken`=1, `Branch_addr`=0x203.
  - Required response: next cycle PC=0x200, `Imem_req`=1, `If_id_valid`=0. The parked instruction never appears on IF/ID.
- **Branch concurrent with ready:**
  - Stimulus: `Branch_taken`=1 in the same cycle as ready with rdata=0xDEAD_BEEF.
  - Required response: 0xDEAD_BEEF is dropped and the next fetch is at the target.
- **Wrap-around:**
  - Stimulus: PC=0xFFFF_FFFC with `Imem_ready`=1.
  - Required response: `If_id_pc`=0x0000_0000 and next `Imem_addr`=0x0000_0000.
- **Asynchronous reset mid-HOLD:**
  - Stimulus: assert `rst_n`=0 between clock edges while in HOLD.
  - Required response: outputs go to reset values immediately, without waiting for a clock edge.
